// File: rtl/instr_dispatch.sv
// Instruction dispatch FSM: fetches an opcode, starts the matching operation FSM
// and supervises its Done handshake with a saturating timeout counter.
module instr_dispatch #(
    parameter int TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] instr,
    output logic       IR_Load,
    output logic       PC_Increment,
    output logic       imm_start,
    output logic       reg_start,
    output logic       mem_start,
    output logic       jmp_start,
    input  logic       imm_done,
    input  logic       reg_done,
    input  logic       mem_done,
    input  logic       jmp_done,
    output logic       busy,
    output logic [2:0] cur_op,
    output logic       halted,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_START, S_WAIT, S_NEXT, S_HALT, S_FAULT
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_IMM  = 3'b001;
    localparam logic [2:0] OP_REG  = 3'b010;
    localparam logic [2:0] OP_MEM  = 3'b011;
    localparam logic [2:0] OP_JMP  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b111;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt;
    logic [3:0] done_vec, sel_mask;
    logic       sel_done, other_done;
    logic       unused_instr;

    assign unused_instr = ^instr[4:0];

    // Line order everywhere is {imm, reg, mem, jmp}.
    assign done_vec = {imm_done, reg_done, mem_done, jmp_done};

    always_comb begin
        sel_mask = 4'b0000;
        case (cur_op)
            OP_IMM:  sel_mask = 4'b1000;
            OP_REG:  sel_mask = 4'b0100;
            OP_MEM:  sel_mask = 4'b0010;
            OP_JMP:  sel_mask = 4'b0001;
            default: sel_mask = 4'b0000;
        endcase
    end

    assign sel_done   = |(done_vec & sel_mask);
    assign other_done = |(done_vec & ~sel_mask);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cur_op   <= 3'b000;
            wait_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE)
                cur_op <= instr[7:5];
            if (state == S_START)
                wait_cnt <= 8'd0;
            else if (state == S_WAIT && wait_cnt != 8'hFF)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Outputs depend only on state and cur_op, so no input reaches an output.
    always_comb begin
        state_nxt    = state;
        IR_Load      = 1'b0;
        PC_Increment = 1'b0;
        imm_start    = 1'b0;
        reg_start    = 1'b0;
        mem_start    = 1'b0;
        jmp_start    = 1'b0;
        busy         = 1'b0;
        halted       = 1'b0;
        fault        = 1'b0;
        case (state)
            S_IDLE: begin
                if (run)
                    state_nxt = S_FETCH;
            end
            S_FETCH: begin
                busy      = 1'b1;
                IR_Load   = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                busy = 1'b1;
                case (instr[7:5])
                    OP_NOP:        state_nxt = S_NEXT;
                    OP_HALT:       state_nxt = S_HALT;
                    3'b101, 3'b110: state_nxt = S_FAULT;
                    default:       state_nxt = S_START;
                endcase
            end
            S_START: begin
                busy = 1'b1;
                {imm_start, reg_start, mem_start, jmp_start} = sel_mask;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                // A stray done beats a simultaneous valid one; completion beats timeout.
                if (other_done)
                    state_nxt = S_FAULT;
                else if (sel_done)
                    state_nxt = run ? S_FETCH : S_IDLE;
                else if (wait_cnt == WAIT_LAST)
                    state_nxt = S_FAULT;
            end
            S_NEXT: begin
                busy         = 1'b1;
                PC_Increment = 1'b1;
                state_nxt    = run ? S_FETCH : S_IDLE;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_dispatch.sv
// Randomized bench for instr_dispatch: each instruction's expected per-cycle
// output trace is built from the opcode, done timing and run level.
module tb_instr_dispatch;

    localparam int TIMEOUT = 32;
    localparam int NEVER   = 1000;

    // Observed vector: {IR_Load, PC_Increment, imm/reg/mem/jmp_start, busy, halted, fault}
    localparam logic [31:0] V_IDLE  = 32'b0_0_0000_0_0_0;
    localparam logic [31:0] V_FETCH = 32'b1_0_0000_1_0_0;
    localparam logic [31:0] V_BUSY  = 32'b0_0_0000_1_0_0;
    localparam logic [31:0] V_NEXT  = 32'b0_1_0000_1_0_0;
    localparam logic [31:0] V_HALT  = 32'b0_0_0000_0_1_0;
    localparam logic [31:0] V_FAULT = 32'b0_0_0000_0_0_1;

    logic       clk = 1'b0;
    logic       reset, run;
    logic [7:0] instr;
    logic       IR_Load, PC_Increment;
    logic       imm_start, reg_start, mem_start, jmp_start;
    logic       imm_done, reg_done, mem_done, jmp_done;
    logic       busy, halted, fault;
    logic [2:0] cur_op;

    int n_cmp = 0;
    int n_err = 0;
    int n_wait;
    int res;

    instr_dispatch #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .run(run), .instr(instr),
        .IR_Load(IR_Load), .PC_Increment(PC_Increment),
        .imm_start(imm_start), .reg_start(reg_start),
        .mem_start(mem_start), .jmp_start(jmp_start),
        .imm_done(imm_done), .reg_done(reg_done),
        .mem_done(mem_done), .jmp_done(jmp_done),
        .busy(busy), .cur_op(cur_op), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] obs();
        return {23'd0, IR_Load, PC_Increment, imm_start, reg_start, mem_start,
                jmp_start, busy, halted, fault};
    endfunction

    // Opcode map: which start/done line an opcode owns, {imm, reg, mem, jmp}.
    function automatic logic [3:0] op_line(input logic [2:0] op);
        case (op)
            3'd1:    return 4'b1000;
            3'd2:    return 4'b0100;
            3'd3:    return 4'b0010;
            3'd4:    return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic noise(input bit en);
        {imm_done, reg_done, mem_done, jmp_done} = en ? 4'($urandom) : 4'b0000;
    endtask

    // Reset asserted between edges; afterwards run stays low until IDLE is confirmed.
    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        chk("rst_async", obs(), V_IDLE);
        chk("rst_cur_op", 32'(cur_op), 32'd0);
        run = 1'b1;
        noise(1);
        step();
        chk("rst_hold", obs(), V_IDLE);
        run = 1'b0;
        noise(0);
        #2 reset = 1'b1;
        step();
        chk("rst_idle", obs(), V_IDLE);
        step();
        chk("rst_idle2", obs(), V_IDLE);
        chk("rst_cur_op2", 32'(cur_op), 32'd0);
        run = 1'b1;
        step();
        chk("rst_fetch", obs(), V_FETCH);
    endtask

    // Starts in FETCH. res: 0 back to FETCH, 1 to IDLE, 2 halted, 3 fault.
    task automatic run_instr(input logic [2:0] op, input int d_sel, input int c_cross,
                             input logic [3:0] xsel_in, input bit rnd, input bit run_final,
                             output int r_out);
        logic [3:0] sel, xsel;
        int  e;
        bit  r;
        sel   = op_line(op);
        instr = {op, 5'($urandom)};
        run   = rnd ? 1'($urandom) : run_final;
        noise(rnd);
        step();
        chk("decode", obs(), V_BUSY);
        run = rnd ? 1'($urandom) : run_final;
        noise(rnd);
        step();
        chk("cur_op", 32'(cur_op), 32'(op));
        instr = 8'($urandom);
        r_out = 0;
        case (op)
            3'd0: begin
                chk("next", obs(), V_NEXT);
                r   = rnd ? 1'($urandom) : run_final;
                run = r;
                noise(rnd);
                step();
                chk("nop_exit", obs(), r ? V_FETCH : V_IDLE);
                r_out = r ? 0 : 1;
            end
            3'd7: begin
                chk("halt", obs(), V_HALT);
                r_out = 2;
            end
            3'd5, 3'd6: begin
                chk("illegal", obs(), V_FAULT);
                r_out = 3;
            end
            default: begin
                chk("start", obs(), {25'd0, sel, 3'b100});
                xsel = xsel_in;
                if (xsel == 4'b0000)
                    do xsel = 4'($urandom) & ~sel; while (xsel == 4'b0000);
                run = rnd ? 1'($urandom) : run_final;
                noise(rnd);
                step();
                e = TIMEOUT - 1;
                if (d_sel < e)   e = d_sel;
                if (c_cross < e) e = c_cross;
                for (int k = 0; k <= e; k++) begin
                    chk("wait", obs(), V_BUSY);
                    r = rnd ? 1'($urandom) : run_final;
                    run = r;
                    {imm_done, reg_done, mem_done, jmp_done} =
                        ((k == d_sel) ? sel : 4'b0000) | ((k == c_cross) ? xsel : 4'b0000);
                    step();
                end
                noise(0);
                n_wait = e + 1;
                if (c_cross == e || d_sel != e) begin
                    chk("wait_fault", obs(), V_FAULT);
                    r_out = 3;
                end else begin
                    chk("wait_exit", obs(), r ? V_FETCH : V_IDLE);
                    r_out = r ? 0 : 1;
                end
            end
        endcase
    endtask

    // Bring the DUT back to FETCH after any outcome.
    task automatic settle(input int r);
        case (r)
            1: begin
                run = 1'b0;
                noise(1);
                step();
                chk("idle_hold", obs(), V_IDLE);
                run = 1'b1;
                noise(0);
                step();
                chk("idle_exit", obs(), V_FETCH);
            end
            2, 3: begin
                run = 1'b1;
                repeat (2) begin
                    noise(1);
                    step();
                    chk("terminal", obs(), (r == 2) ? V_HALT : V_FAULT);
                end
                noise(0);
                do_reset();
            end
            default: ;
        endcase
    endtask

    initial begin
        logic [2:0] op;
        int d, c;
        reset = 1'b0;
        run   = 1'b0;
        instr = 8'h00;
        noise(0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", obs(), V_IDLE);
        chk("reset_cur_op", 32'(cur_op), 32'd0);
        #2 reset = 1'b1;
        step();
        chk("idle_run0", obs(), V_IDLE);
        step();
        chk("idle_run0b", obs(), V_IDLE);
        run = 1'b1;
        step();
        chk("first_fetch", obs(), V_FETCH);

        // IMM, done 8 cycles after the start pulse
        run_instr(3'd1, 7, NEVER, 4'b0000, 0, 1, res);
        chk("imm_res", res, 0);
        // NOP then HALT
        run_instr(3'd0, NEVER, NEVER, 4'b0000, 0, 1, res);
        chk("nop_res", res, 0);
        run_instr(3'd7, NEVER, NEVER, 4'b0000, 0, 1, res);
        chk("halt_res", res, 2);
        settle(res);
        // Illegal opcode 0xA0
        run_instr(3'd5, NEVER, NEVER, 4'b0000, 0, 1, res);
        chk("illegal_res", res, 3);
        settle(res);
        // Timeout: no mem_done ever, then mem_done on the last allowed cycle
        run_instr(3'd3, NEVER, NEVER, 4'b0000, 0, 1, res);
        chk("timeout_res", res, 3);
        chk("timeout_cycles", n_wait, TIMEOUT);
        settle(res);
        run_instr(3'd3, TIMEOUT - 1, NEVER, 4'b0000, 0, 1, res);
        chk("late_done_res", res, 0);
        // Cross-done alone, and together with the selected done
        run_instr(3'd2, NEVER, 2, 4'b0001, 0, 1, res);
        chk("cross_res", res, 3);
        settle(res);
        run_instr(3'd2, 4, 4, 4'b0001, 0, 1, res);
        chk("cross_same_res", res, 3);
        settle(res);
        // run low throughout: instruction completes, then IDLE
        run_instr(3'd4, 5, NEVER, 4'b0000, 0, 0, res);
        chk("run_low_res", res, 1);
        settle(res);
        // Reset during START and during WAIT
        instr = 8'h60;
        step();
        step();
        chk("mid_start", obs(), {25'd0, op_line(3'd3), 3'b100});
        do_reset();
        instr = 8'h20;
        step();
        step();
        step();
        chk("mid_wait", obs(), V_BUSY);
        do_reset();

        for (int i = 0; i < 80; i++) begin
            op = 3'($urandom_range(0, 7));
            d  = $urandom_range(0, TIMEOUT + 4);
            if (d >= TIMEOUT) d = NEVER;
            c  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, TIMEOUT) : NEVER;
            run_instr(op, d, c, 4'b0000, 1, 1, res);
            settle(res);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
